// File: rtl/vermicom_pkg.sv
// Shared types and constants for the Vermicom UART receive/transmit path.
package vermicom_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned MIN_DIVISION = 2;

endpackage

// File: rtl/vermicom_bit_timer.sv
// Loadable down-counter; o_tick is high while the count sits at zero.
module vermicom_bit_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tick = (r_count == '0);

endmodule

// File: rtl/vermicom_rx_core.sv
// 8N1 serial receive engine: synchronises rxd, mid-bit samples at the latched
// DIVISION rate and delivers each framed byte with a one-cycle pulse.
module vermicom_rx_core #(
  parameter int unsigned DIVISION_WIDTH = 32,
  parameter int unsigned DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIVISION_WIDTH-1:0] division,
  input  logic                      rxd,
  output logic [DATA_BITS-1:0]      rx_data,
  output logic                      rx_valid,
  output logic                      frame_error,
  output logic                      busy
);

  import vermicom_pkg::*;

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                      r_rxd_m;
  logic                      r_rxd_s;
  rx_state_t                 r_state;
  logic [DIVISION_WIDTH-1:0] r_div_q;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]      r_shift;
  logic [DATA_BITS-1:0]      r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_error;

  logic [DIVISION_WIDTH-1:0] w_div_clamped;
  logic                      w_load;
  logic [DIVISION_WIDTH-1:0] w_load_value;
  logic                      w_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_rxd_m <= rxd;
      r_rxd_s <= r_rxd_m;
    end
  end

  assign w_div_clamped = (division < DIVISION_WIDTH'(MIN_DIVISION)) ?
                         DIVISION_WIDTH'(MIN_DIVISION) : division;

  // Half-period load at the start edge uses the live clamped value because
  // r_div_q is only captured on that same edge.
  always_comb begin
    w_load       = 1'b0;
    w_load_value = r_div_q - DIVISION_WIDTH'(1);
    if ((r_state == RX_IDLE) && !r_rxd_s) begin
      w_load       = 1'b1;
      w_load_value = (w_div_clamped >> 1) - DIVISION_WIDTH'(1);
    end else if (w_tick && ((r_state == RX_START) || (r_state == RX_DATA))) begin
      w_load = 1'b1;
    end
  end

  vermicom_bit_timer #(
    .WIDTH(DIVISION_WIDTH)
  ) u_bit_timer (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_tick       (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RX_IDLE;
      r_div_q       <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_rxd_s) begin
            r_div_q <= w_div_clamped;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rxd_s) begin
              r_state <= RX_IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rxd_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= RX_IDLE;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // Hold off until the line recovers so a stuck-low rxd cannot re-trigger.
          if (r_rxd_s) begin
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state != RX_IDLE);

endmodule

// File: tb/tb_vermicom_rx_core.sv
// Self-checking bench for vermicom_rx_core: table vectors, hand-written corner
// sequences and random frame streams against a sample-point event model.
module tb_vermicom_rx_core;

  localparam int MAXN = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] division = 32'd4;
  logic        rxd = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_error;
  logic        busy;

  always #5 clk = ~clk;

  vermicom_rx_core #(
    .DIVISION_WIDTH(32),
    .DATA_BITS(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .division   (division),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  bit          line [MAXN];
  int unsigned divv [MAXN];
  int          n;
  bit          ev_valid [MAXN];
  bit          ev_ferr  [MAXN];
  bit          ev_busy  [MAXN];
  logic [7:0]  ev_data  [MAXN];

  int checks = 0;
  int errors = 0;

  int         st_nvalid, st_nferr, st_first, st_busy_cnt;
  logic [7:0] st_last_data;
  int         vcyc [$];
  logic [7:0] vdat [$];

  typedef struct {
    int unsigned div;
    logic [7:0]  data;
    bit          stop;
    int          extra_low;
    int          exp_valid;
    int          exp_ferr;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl [8];

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic bit rs(input int c);
    if (c < 2) return 1'b1;
    if (c - 2 >= n) return 1'b1;
    return line[c-2];
  endfunction

  task automatic push(input bit v, input int unsigned d);
    if (n < MAXN) begin
      line[n] = v;
      divv[n] = d;
      n++;
    end
  endtask

  task automatic add_bits(input bit v, input int len, input int unsigned d);
    for (int i = 0; i < len; i++) push(v, d);
  endtask

  // One frame; the division input switches to d_late three cycles in.
  task automatic add_frame(input int unsigned d, input logic [7:0] b, input bit stop,
                           input int stoplen, input int extra_low, input int unsigned d_late);
    int bl;
    int k;
    bl = (d < 2) ? 2 : int'(d);
    k = 0;
    for (int i = 0; i < bl; i++) begin push(1'b0, (k < 3) ? d : d_late); k++; end
    for (int bi = 0; bi < 8; bi++)
      for (int i = 0; i < bl; i++) begin push(b[bi], (k < 3) ? d : d_late); k++; end
    for (int i = 0; i < stoplen; i++) begin push(stop, d_late); k++; end
    add_bits(1'b0, extra_low, d_late);
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int c = from; c <= to; c++)
      if (c >= 0 && c < MAXN) ev_busy[c] = 1'b1;
  endtask

  // Expected outputs per cycle, derived from the sample-point timing rules.
  task automatic model();
    int t, dq, h, st, s, c;
    logic [7:0] byte_v;
    logic [7:0] cur;
    for (int i = 0; i < MAXN; i++) begin
      ev_valid[i] = 1'b0; ev_ferr[i] = 1'b0; ev_busy[i] = 1'b0; ev_data[i] = 8'h00;
    end
    t = 0;
    while (t < n) begin
      if (rs(t) == 1'b0) begin
        dq = (divv[t] < 2) ? 2 : int'(divv[t]);
        h  = dq / 2;
        st = t + h;
        if (rs(st) == 1'b1) begin
          mark_busy(t + 1, st);
          t = st + 1;
        end else begin
          for (int k = 0; k < 8; k++) byte_v[k] = rs(t + h + (k + 1) * dq);
          s = t + h + 9 * dq;
          if (rs(s) == 1'b1) begin
            mark_busy(t + 1, s);
            if (s + 1 < MAXN) begin ev_valid[s+1] = 1'b1; ev_data[s+1] = byte_v; end
            t = s + 1;
          end else begin
            c = s + 1;
            while (rs(c) == 1'b0 && c < MAXN) c++;
            mark_busy(t + 1, c);
            if (s + 1 < MAXN) ev_ferr[s+1] = 1'b1;
            t = c + 1;
          end
        end
      end else begin
        t++;
      end
    end
    cur = 8'h00;
    for (int i = 0; i < MAXN; i++) begin
      if (ev_valid[i]) cur = ev_data[i];
      ev_data[i] = cur;
    end
  endtask

  task automatic run_stream(input string tag);
    model();
    @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    st_nvalid = 0; st_nferr = 0; st_first = -1; st_busy_cnt = 0;
    vcyc.delete(); vdat.delete();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rxd      = line[c];
      division = divv[c];
      @(negedge clk);
      checks++;
      if ({rx_valid, frame_error, busy} !== {ev_valid[c], ev_ferr[c], ev_busy[c]}) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: got valid/ferr/busy=%b%b%b want %b%b%b", tag, c,
                 rx_valid, frame_error, busy, ev_valid[c], ev_ferr[c], ev_busy[c]);
      end
      checks++;
      if (rx_data !== ev_data[c]) begin
        errors++;
        $display("FAIL %s rx_data cycle %0d: got %h want %h", tag, c, rx_data, ev_data[c]);
      end
      if (rx_valid === 1'b1) begin st_nvalid++; vcyc.push_back(c); vdat.push_back(rx_data); end
      if (frame_error === 1'b1) st_nferr++;
      if (busy === 1'b1) st_busy_cnt++;
      if (st_first < 0 && (rx_valid === 1'b1 || frame_error === 1'b1)) st_first = c;
      st_last_data = rx_data;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d, dl;
    int bl, h, kind, stoplen, extra;
    bit stop;

    // div, data, stop, extra_low, exp_valid, exp_ferr, exp_data, first pulse - frame start
    tbl[0] = '{4,  8'h55, 1'b1, 0,  1, 0, 8'h55, 41};
    tbl[1] = '{16, 8'hA3, 1'b1, 0,  1, 0, 8'hA3, 155};
    tbl[2] = '{4,  8'hFF, 1'b0, 20, 0, 1, 8'h00, 41};
    tbl[3] = '{3,  8'h00, 1'b1, 0,  1, 0, 8'h00, 31};
    tbl[4] = '{2,  8'h81, 1'b1, 0,  1, 0, 8'h81, 22};
    tbl[5] = '{0,  8'h5A, 1'b1, 0,  1, 0, 8'h5A, 22};
    tbl[6] = '{1,  8'hC3, 1'b1, 0,  1, 0, 8'hC3, 22};
    tbl[7] = '{7,  8'h96, 1'b1, 0,  1, 0, 8'h96, 69};

    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, frame_error, busy} !== 3'b000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got v/f/b=%b%b%b data=%h want 000 data=00",
               rx_valid, frame_error, busy, rx_data);
    end

    for (int i = 0; i < 8; i++) begin
      n = 0;
      bl = (tbl[i].div < 2) ? 2 : int'(tbl[i].div);
      add_bits(1'b1, 5, tbl[i].div);
      add_frame(tbl[i].div, tbl[i].data, tbl[i].stop, bl, tbl[i].extra_low, tbl[i].div);
      add_bits(1'b1, 30, tbl[i].div);
      run_stream($sformatf("vec%0d", i));
      check_int($sformatf("vec%0d_valid_count", i), st_nvalid, tbl[i].exp_valid);
      check_int($sformatf("vec%0d_ferr_count", i), st_nferr, tbl[i].exp_ferr);
      check_int($sformatf("vec%0d_rx_data", i), int'(st_last_data), int'(tbl[i].exp_data));
      check_int($sformatf("vec%0d_latency", i), st_first - 5, tbl[i].exp_lat);
    end

    // False start: two low cycles at division 8.
    n = 0;
    add_bits(1'b1, 5, 8);
    add_bits(1'b0, 2, 8);
    add_bits(1'b1, 30, 8);
    run_stream("false_start");
    check_int("false_start_valid", st_nvalid, 0);
    check_int("false_start_ferr", st_nferr, 0);
    check_int("false_start_busy_cycles", st_busy_cnt, 4);

    // Back-to-back frames at division 16.
    n = 0;
    add_bits(1'b1, 5, 16);
    add_frame(16, 8'hA3, 1'b1, 16, 0, 16);
    add_frame(16, 8'h0F, 1'b1, 16, 0, 16);
    add_bits(1'b1, 30, 16);
    run_stream("b2b");
    check_int("b2b_valid_count", st_nvalid, 2);
    if (vcyc.size() == 2) begin
      check_int("b2b_spacing", vcyc[1] - vcyc[0], 160);
      check_int("b2b_byte0", int'(vdat[0]), 8'hA3);
      check_int("b2b_byte1", int'(vdat[1]), 8'h0F);
    end

    // Division 0 clamps to 2; a change to 100 mid-frame is ignored.
    n = 0;
    add_bits(1'b1, 5, 0);
    add_frame(0, 8'h81, 1'b1, 2, 0, 100);
    add_bits(1'b1, 30, 100);
    run_stream("clamp_latch");
    check_int("clamp_valid_count", st_nvalid, 1);
    if (vdat.size() == 1) check_int("clamp_byte", int'(vdat[0]), 8'h81);

    // Reset during data bit 3 of 0x3C, then a clean 0xC3 frame.
    n = 0;
    add_bits(1'b1, 5, 4);
    add_frame(4, 8'h3C, 1'b1, 4, 0, 4);
    n = 5 + 18;
    run_stream("abort_pre");
    check_int("abort_busy_before", int'(busy), 1);
    #2;
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    check_int("abort_busy_async", int'(busy), 0);
    check_int("abort_pulses_async", int'({rx_valid, frame_error}), 0);
    n = 0;
    add_bits(1'b1, 5, 4);
    add_frame(4, 8'hC3, 1'b1, 4, 0, 4);
    add_bits(1'b1, 30, 4);
    run_stream("abort_post");
    check_int("abort_post_valid", st_nvalid, 1);
    check_int("abort_post_data", int'(st_last_data), 8'hC3);

    // Random frame streams: glitches, bad stops, short stops, division changes.
    for (int s = 0; s < 2; s++) begin
      n = 0;
      add_bits(1'b1, $urandom_range(4, 9), 4);
      for (int f = 0; f < 25; f++) begin
        d    = $urandom_range(0, 12);
        bl   = (d < 2) ? 2 : int'(d);
        h    = bl / 2;
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
          add_bits(1'b0, $urandom_range(1, bl), d);
          add_bits(1'b1, 11 * bl, d);
        end else begin
          stop    = (kind != 1);
          extra   = stop ? 0 : $urandom_range(0, 15);
          stoplen = stop ? (h + 1 + $urandom_range(0, bl - h - 1)) : bl;
          dl      = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : d;
          add_frame(d, 8'($urandom), stop, stoplen, extra, dl);
          add_bits(1'b1, $urandom_range(0, 3) + (stop ? 0 : 1), d);
        end
      end
      add_bits(1'b1, 200, 4);
      run_stream($sformatf("rand%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vermicom_rx_core.md
Name: vermicom_rx_core

Overview:
- Serial receive engine for the Vermicom UART device; sits directly upstream of the Vermicom register file.
- Deserialises 8N1 frames from the asynchronous `rxd` line, timed by the DIVISION register value (clock cycles per bit).
- Delivers the received byte to the DATA register with a one-cycle pulse; that pulse autosets `status.rx_event_flag` and may raise the RX IRQ when `control.rx_irq_enable` is set.

Parameters:
- DIVISION_WIDTH, 32, width of the bit-period input; matches the data bus width of the DIVISION register.
- DATA_BITS, 8, payload bits per frame; LSB first, no parity, one stop bit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- division  input  DIVISION_WIDTH  bit period in clk cycles, taken from the DIVISION register.
- rxd  input  1  asynchronous serial input; idle level is 1.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high while a frame is in progress, i.e. any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all counters 0.
  - Synchroniser flops=1.
  - rx_data=0, rx_valid=0, frame_error=0, busy=0.
- Input synchronisation: `rxd` passes through 2 flops (rxd_s); 2-cycle latency. All decisions use rxd_s.
- Division latch: on leaving IDLE, `div_q` = max(division, 2). Changes to `division` mid-frame have no effect until the next frame.
- Timing: let D be the first cycle in IDLE where rxd_s==0. Samples are taken at:
  - start bit: cycle D+H, where H = div_q>>1;
  - data bit k (k=0..7): cycle D+H+(k+1)*div_q;
  - stop bit: cycle D+H+9*div_q.
- Bit timer: a down-counter loaded with H-1 at D and with div_q-1 after each sample. A sample is taken when the counter reaches 0.
- State machine:
  - IDLE: rxd_s==0 -> START.
  - START: at the sample, rxd_s==1 -> IDLE (false start, no pulse); rxd_s==0 -> DATA with bit index=0.
  - DATA: at each sample, shift rxd_s into the MSB of the shift register (LSB-first reception). After bit 7 -> STOP.
  - STOP: at the sample:
    - rxd_s==1: rx_data <= shift register; rx_valid=1 in the next cycle; -> IDLE.
    - rxd_s==0: frame_error=1 in the next cycle; rx_data unchanged; -> BREAK.
  - BREAK: wait until rxd_s==1, then -> IDLE. This prevents a held-low line from re-triggering.
- Output pulses: rx_valid and frame_error are registered, last exactly one cycle, and are never high together.
- Back-to-back frames: IDLE is re-entered in the cycle after the stop sample, so a start edge mid-way through the stop bit is accepted. No consumer handshake; a byte not read before the next rx_valid is overwritten. The overrun policy belongs to the register file.
- Reset mid-frame: aborts immediately, with no pulse. After reset release the block sits in IDLE; if rxd is still low, it treats that as a new start edge. This is accepted behaviour.
- Counter width: DIVISION_WIDTH bits. The counter must not underflow for div_q=2, where H=1 and the start bit is sampled at D+1.

Decomposition:
- Vermicom_pkg additions:
  - rx_state_t enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK};
  - localparam DATA_BITS=8;
  - localparam MIN_DIVISION=2.
- Sub-module vermicom_bit_timer: loadable down-counter with a `tick` output at zero. The future vermicom_tx_core reuses it.
- The synchroniser stays inline.

Test Plan:
- division=4, send 0x55 (start, bits 1,0,1,0,1,0,1,0, stop=1) -> rx_valid pulses once at D+2+36+1; rx_data=0x55; frame_error never high.
- division=16, send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_valid pulses 160 cycles apart; rx_data=0xA3 then 0x0F.
- division=8, rxd low for 2 cycles then high -> START sample sees 1; returns to IDLE; no rx_valid or frame_error; busy high for 4 cycles only.
- division=4, send 0xFF with stop bit=0, line held low for 20 more cycles -> frame_error pulses once; rx_data keeps its previous value; busy stays high until rxd returns to 1.
- division=4, assert reset during data bit 3 of 0x3C, release, then send 0xC3 -> no pulse for the aborted frame; rx_data=0xC3 after the second frame.
- division=0, send 0x81 at 2 cycles/bit; change division to 100 mid-frame -> received as 0x81, proving the clamp to 2 and the frame-start latch.
